// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
    localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer for an asynchronous input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with sticky done/overrun flags and a frame-error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      uart_rxd,
    input  logic                      rx_clear,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_done,
    output logic                      overrun,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic                      rxd_s;
    uart_rx_state_t            state, state_n;
    logic [CW-1:0]             cnt, cnt_n;
    logic [2:0]                idx, idx_n;
    logic [UART_DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic                      done_n, ovr_n, ferr_n;
    logic                      expired;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (uart_rxd),
        .q       (rxd_s)
    );

    assign expired = (cnt == '0);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            rx_data   <= data_n;
            rx_done   <= done_n;
            overrun   <= ovr_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = expired ? cnt : cnt - 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = rx_data;
        done_n  = rx_clear ? 1'b0 : rx_done;
        ovr_n   = rx_clear ? 1'b0 : overrun;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    cnt_n   = HALF;
                    state_n = START;
                end
            end
            START: begin
                if (expired) begin
                    if (rxd_s) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n   = FULL;
                        idx_n   = '0;
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shreg_n = {rxd_s, shreg[UART_DATA_BITS-1:1]};
                    cnt_n   = FULL;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end
            end
            STOP: begin
                if (expired) begin
                    if (rxd_s) begin
                        state_n = IDLE;
                        // A clear in the delivery cycle frees the slot for the new byte.
                        if (!rx_done || rx_clear) begin
                            data_n = shreg;
                            done_n = 1'b1;
                        end else begin
                            ovr_n = 1'b1;
                        end
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench; every change on the receive outputs must match the next queued expectation.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_clear = 1'b0;
    logic [7:0] rx_data;
    logic       rx_done, overrun, frame_err, busy;

    typedef struct packed {
        logic [7:0] d;
        logic       done;
        logic       ovr;
        logic       ferr;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rise_cyc = -1;
    int   ferr_cycles = 0;
    int   t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .uart_rxd  (uart_rxd),
        .rx_clear  (rx_clear),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    function automatic obs_t mk(logic [7:0] d, logic done, logic ovr, logic ferr);
        return '{d: d, done: done, ovr: ovr, ferr: ferr};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [7:0] b, int stop_len = CPB, logic stop_val = 1'b1, logic clr = 1'b0);
        uart_rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            tick(CPB);
        end
        uart_rxd = stop_val;
        for (int c = 0; c < stop_len; c++) begin
            rx_clear = clr && (c == CPB - 2);
            tick(1);
        end
        rx_clear = 1'b0;
        uart_rxd = 1'b1;
    endtask

    task automatic pulse_clear();
        rx_clear = 1'b1;
        tick(1);
        rx_clear = 1'b0;
    endtask

    initial begin
        obs_t prev, cur, e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {rx_data, rx_done, overrun, frame_err};
            if (frame_err === 1'b1) ferr_cycles++;
            if (cur.done && !prev.done) rise_cyc = cyc;
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_change: got %0h, no change expected (was %0h)", cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_event", cur, e);
                end
                prev = cur;
            end
        end
    end

    initial begin
        tick(3);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_done", rx_done, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_busy", busy, 0);
        reset_n = 1'b1;
        tick(2);

        exp_q.push_back(mk(8'hCC, 1, 0, 0));
        t0 = cyc;
        send(8'hCC);
        chk("t1_latency", rise_cyc - t0, 79);
        tick(2);
        chk("t1_busy_after", busy, 0);
        chk("t1_rx_data", rx_data, 8'hCC);
        exp_q.push_back(mk(8'hCC, 0, 0, 0));
        pulse_clear();
        tick(2);

        exp_q.push_back(mk(8'hA5, 1, 0, 0));
        send(8'hA5);
        exp_q.push_back(mk(8'hA5, 1, 1, 0));
        send(8'h3C);
        tick(2);
        chk("t2_rx_data_kept", rx_data, 8'hA5);
        chk("t2_overrun", overrun, 1);
        exp_q.push_back(mk(8'hA5, 0, 0, 0));
        pulse_clear();
        tick(2);
        chk("t2_done_cleared", rx_done, 0);
        chk("t2_overrun_cleared", overrun, 0);

        uart_rxd = 1'b0;
        tick(2);
        uart_rxd = 1'b1;
        tick(3);
        chk("t3_busy_in_start", busy, 1);
        tick(6);
        chk("t3_busy_after_glitch", busy, 0);

        exp_q.push_back(mk(8'hA5, 0, 0, 1));
        exp_q.push_back(mk(8'hA5, 0, 0, 0));
        send(8'h55, 40, 1'b0);
        chk("t4_busy_in_break", busy, 1);
        tick(5);
        chk("t4_busy_after_break", busy, 0);
        chk("t4_ferr_pulse_width", ferr_cycles, 1);
        chk("t4_rx_done_unchanged", rx_done, 0);
        exp_q.push_back(mk(8'h81, 1, 0, 0));
        send(8'h81);
        tick(2);
        chk("t4_rx_data_after", rx_data, 8'h81);

        exp_q.push_back(mk(8'h7E, 1, 0, 0));
        send(8'h7E, CPB, 1'b1, 1'b1);
        tick(2);
        chk("t5_rx_data", rx_data, 8'h7E);
        chk("t5_rx_done", rx_done, 1);
        chk("t5_overrun", overrun, 0);

        exp_q.push_back(mk(8'h00, 0, 0, 0));
        uart_rxd = 1'b0;
        tick(30);
        chk("t6_busy_in_data", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_rx_data", rx_data, 8'h00);
        chk("t6_rst_rx_done", rx_done, 0);
        chk("t6_rst_overrun", overrun, 0);
        chk("t6_rst_busy", busy, 0);
        tick(3);
        uart_rxd = 1'b1;
        reset_n = 1'b1;
        tick(4);
        exp_q.push_back(mk(8'hFF, 1, 0, 0));
        send(8'hFF);
        tick(3);
        chk("t6_rx_data_after", rx_data, 8'hFF);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the terminal peripheral's receive path. It samples the asynchronous `uart_rxd` line, deframes 8N1 characters (1 start, 8 data LSB-first, 1 stop) and holds the last good byte with a sticky done flag. The terminal block reads these as its receive-byte and receive-done registers (addresses 3 and 4), and clears the flag by writing 0 to address 4 (`rx_clear`).

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range is 4 or more.
- `clk`  in  1: system clock; all logic on the rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `uart_rxd`  in  1: serial input, asynchronous to `clk`, idles high.
- `rx_clear`  in  1: single-cycle pulse; clears `rx_done` and `overrun`.
- `rx_data`  out  8: last correctly framed byte.
- `rx_done`  out  1: sticky; a byte is waiting in `rx_data`.
- `overrun`  out  1: sticky; a byte was dropped because `rx_done` was still set.
- `frame_err`  out  1: one-cycle pulse; the stop bit sampled low.
- `busy`  out  1: high in every state except IDLE.

## Operation
- **Input synchronizer.** Two flops, both reset to 1. All decisions use the synchronized bit `rxd_s`.
- **Counters.**
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide and counts down.
  - Bit index is 3 bits.
  - Shift register is 8 bits and shifts right, with the new bit entering at [7].
- **IDLE.** On `rxd_s`==0: load the counter with CLKS_PER_BIT/2 - 1 (integer division) and go to START.
- **START.** When the counter reaches 0, re-sample `rxd_s`:
  - 1 means a glitch; return to IDLE with no outputs changed.
  - 0 means a valid start bit; load CLKS_PER_BIT-1, clear the bit index, go to DATA.
- **DATA.** At each counter expiry, sample `rxd_s` into the shift register and reload CLKS_PER_BIT-1. After the sample with bit index 7, go to STOP; otherwise increment the index.
- **STOP.** At counter expiry, sample `rxd_s`:
  - 1 means a good frame; deliver the byte (rules below) and go to IDLE.
  - 0 means a framing error; pulse `frame_err`, discard the byte, go to BREAK.
- **BREAK.** Stay until `rxd_s`==1, then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- **Delivery rules.**
  - If `rx_done`==0, or `rx_clear` is high in the same cycle: load `rx_data` and set `rx_done`=1.
  - Otherwise: keep the old `rx_data`, set `overrun`=1, and leave `rx_done`=1.
- **`rx_clear` without a delivery.** Sets `rx_done`=0 and `overrun`=0. When it coincides with a delivery, `overrun` clears and `rx_done` stays 1.
- **Reset.** Asynchronous; aborts any frame in progress.
  - State goes to IDLE; counters and shift register go to 0.
  - Outputs: `rx_data`=8'h00, `rx_done`=0, `overrun`=0, `frame_err`=0, `busy`=0.

## Timing
- Synchronizer latency is 2 cycles from a `uart_rxd` edge to `rxd_s`.
- The start bit is confirmed CLKS_PER_BIT/2 cycles after IDLE sees `rxd_s` low.
- Each data bit and the stop bit are sampled at CLKS_PER_BIT-cycle intervals from the confirmation, i.e. mid-bit.
- `rx_done`, `rx_data` and `frame_err` update in the cycle after the stop sample. From the start-bit falling edge on `uart_rxd` this is about 9.5·CLKS_PER_BIT + 3 cycles.
- `rx_done` stays high until `rx_clear`, with no timeout.
- Back-to-back frames need no idle gap: IDLE accepts a new start bit in the first cycle after STOP.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_t` enum {IDLE, START, DATA, STOP, BREAK}.
  - Constant `UART_DEFAULT_CLKS_PER_BIT` = 434.
  - Constant `UART_DATA_BITS` = 8.
- One sub-module, `sync_2ff`: a 1-bit, two-flop synchronizer with a reset value parameter. The FSM, counters and output registers stay in `uart_rx`.

## Test plan
All scenarios use CLKS_PER_BIT=8 and drive exact bit periods.
1. Send 8'hCC -> `rx_done` rises 1 cycle after the stop sample, `rx_data`=8'hCC, `frame_err` never pulses, `busy` low afterwards.
2. Send 8'hA5 then 8'h3C back-to-back without `rx_clear` -> `rx_data` stays 8'hA5, `overrun`=1. Then pulse `rx_clear` -> `rx_done`=0, `overrun`=0.
3. Pulse `uart_rxd` low for 2 cycles -> FSM returns to IDLE, no output changes, `busy` deasserts.
4. Send 8'h55 with the stop bit held low for 40 cycles -> one-cycle `frame_err`, `rx_done` unchanged, FSM in BREAK until the line is high. A following 8'h81 is received correctly.
5. With a byte pending, assert `rx_clear` in the same cycle as delivery of 8'h7E -> `rx_data`=8'h7E, `rx_done`=1, `overrun`=0.
6. Assert `reset_n` low in the middle of DATA -> all outputs take their reset values immediately. After release, 8'hFF is received correctly.
